dac_channel_scheduler: RTL and testbench

Shares one serial 24-bit DAC interface (SYNC/SCLK/DIN) between N_CH sample sources such as sine generators and tone channels.
- Round-robin arbitration across requesters with a valid/ready handshake.
- Builds a command/address/data frame for each accepted sample and shifts it out MSB first.
- Reports frame completion so upstream sources can pace themselves.

---
 rtl/dac_channel_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_dac_channel_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_channel_scheduler.sv
// Round-robin scheduler sharing one 24-bit serial DAC port (SYNC/SCLK/DIN) among N_CH sources.
// Optional `DAC_LDAC_EN: write-only frames plus a deferred LDAC_N pulse once every channel is written.
module dac_channel_scheduler #(
   parameter int         N_CH      = 4,
   parameter int         CLK_DIV   = 2,
   parameter int         SYNC_HI   = 2,
   parameter logic [3:0] CMD_WRUPD = 4'h3,
   parameter logic [3:0] CMD_WR    = 4'h0
) (
   input  logic                 CLK_100,
   input  logic                 RESET_N,
   input  logic [16*N_CH-1:0]   CH_DATA,
   input  logic [N_CH-1:0]      CH_VALID,
`ifdef DAC_LDAC_EN
   output logic                 LDAC_N,
`endif
   output logic [N_CH-1:0]      CH_READY,
   output logic                 SYNC,
   output logic                 SCLK,
   output logic                 DIN,
   output logic                 BUSY,
   output logic                 FRAME_DONE,
   output logic [3:0]           FRAME_CH
);

   localparam int PTR_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CNT_MAX = (2*CLK_DIV > SYNC_HI) ? 2*CLK_DIV : SYNC_HI;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef DAC_LDAC_EN
   localparam bit LDAC_EN = 1'b1;
`else
   localparam bit LDAC_EN = 1'b0;
`endif
   localparam logic [3:0] CMD_NIB = LDAC_EN ? CMD_WR : CMD_WRUPD;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_GAP} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [4:0]          bit_q, bit_d;
   logic [PTR_W-1:0]    grant_q, grant_d;
   logic [PTR_W-1:0]    rr_q, rr_d;
   logic [23:0]         frame_q, frame_d;

   logic                found;
   logic [PTR_W-1:0]    pick;
   int                  idx;
   logic [N_CH-1:0]     grant_oh;
   logic                gap_first, gap_last, stall;

   // First valid requester at or after the round-robin pointer, wrapping.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      found = 1'b0;
      pick  = rr_q;
      idx   = 0;
      for (int k = 0; k < N_CH; k++) begin
         idx = (int'(rr_q) + k) % N_CH;
         if (!found && CH_VALID[idx]) begin
            found = 1'b1;
            pick  = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      grant_oh          = '0;
      grant_oh[grant_q] = 1'b1;
   end

   assign gap_first = (state_q == S_GAP) && (cnt_q == '0);
   assign gap_last  = (state_q == S_GAP) && (cnt_q == CNT_W'(SYNC_HI - 1));

   always_ff @(posedge CLK_100 or negedge RESET_N) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!RESET_N) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      frame_d = frame_q;
      unique case (state_q)
         S_IDLE: begin
            if (stall) begin
               cnt_d = (cnt_q == CNT_W'(2*CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
            end else if (found) begin
               grant_d = pick;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            frame_d = {CMD_NIB, 4'(grant_q), CH_DATA[16*int'(grant_q) +: 16]};
            rr_d    = (grant_q == PTR_W'(N_CH - 1)) ? '0 : grant_q + 1'b1;
            bit_d   = 5'd23;
            cnt_d   = '0;
            state_d = S_SHIFT_LO;
         end
         S_SHIFT_LO: begin
            if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
               cnt_d   = '0;
               state_d = S_SHIFT_HI;
            end else cnt_d = cnt_q + 1'b1;
         end
         S_SHIFT_HI: begin
            if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
               cnt_d = '0;
               if (bit_q == 5'd0) state_d = S_GAP;
               else begin
                  bit_d   = bit_q - 5'd1;
                  state_d = S_SHIFT_LO;
               end
            end else cnt_d = cnt_q + 1'b1;
         end
         S_GAP: begin
            if (gap_last) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else cnt_d = cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK_100 or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q   <= '0;
         bit_q   <= '0;
         grant_q <= '0;
         rr_q    <= '0;
         frame_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         frame_q <= frame_d;
      end
   end

`ifdef DAC_LDAC_EN
   logic [N_CH-1:0] mask_q, mask_d;
   logic            pend_q, pend_d, act_q, act_d, full_now;

   // The pulse starts on the first IDLE cycle after the GAP that completed the set.
   always_comb begin
      mask_d   = mask_q;
      pend_d   = pend_q;
      act_d    = act_q;
      full_now = gap_first && ((mask_q | grant_oh) == '1);
      if (gap_first) mask_d = full_now ? '0 : (mask_q | grant_oh);
      if (full_now) pend_d = 1'b1;
      if (gap_last && (pend_q || full_now)) begin
         act_d  = 1'b1;
         pend_d = 1'b0;
      end
      if (act_q && (state_q == S_IDLE) && (cnt_q == CNT_W'(2*CLK_DIV - 1))) act_d = 1'b0;
   end

   always_ff @(posedge CLK_100 or negedge RESET_N) begin
      if (!RESET_N) begin
         mask_q <= '0;
         pend_q <= 1'b0;
         act_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         pend_q <= pend_d;
         act_q  <= act_d;
      end
   end

   assign stall  = act_q;
   assign LDAC_N = ~act_q;
`else
   assign stall = 1'b0;
`endif

   always_comb begin
      SYNC       = 1'b1;
      SCLK       = 1'b0;
      DIN        = 1'b0;
      CH_READY   = '0;
      BUSY       = (state_q != S_IDLE);
      FRAME_DONE = gap_first;
      FRAME_CH   = gap_first ? 4'(grant_q) : 4'd0;
      unique case (state_q)
         S_LOAD:     CH_READY = grant_oh;
         S_SHIFT_LO: begin
            SYNC = 1'b0;
            DIN  = frame_q[bit_q];
         end
         S_SHIFT_HI: begin
            SYNC = 1'b0;
            SCLK = 1'b1;
            DIN  = frame_q[bit_q];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Directed bench for dac_channel_scheduler: reset, single frame, round-robin, skip/wrap, valid drop.
// Define DAC_LDAC_EN on the command line to also exercise the deferred LDAC_N pulse.
module tb_dac_channel_scheduler;

   localparam int N       = 4;
   localparam int CLK_DIV = 2;

   logic            CLK_100 = 1'b0;
   logic            RESET_N;
   logic [16*N-1:0] CH_DATA;
   logic [N-1:0]    CH_VALID;
   logic [N-1:0]    CH_READY;
   logic            SYNC, SCLK, DIN, BUSY, FRAME_DONE;
   logic [3:0]      FRAME_CH;
`ifdef DAC_LDAC_EN
   logic            LDAC_N;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc_cnt  = 0;

   dac_channel_scheduler dut (
      .CLK_100   (CLK_100),
      .RESET_N   (RESET_N),
      .CH_DATA   (CH_DATA),
      .CH_VALID  (CH_VALID),
`ifdef DAC_LDAC_EN
      .LDAC_N    (LDAC_N),
`endif
      .CH_READY  (CH_READY),
      .SYNC      (SYNC),
      .SCLK      (SCLK),
      .DIN       (DIN),
      .BUSY      (BUSY),
      .FRAME_DONE(FRAME_DONE),
      .FRAME_CH  (FRAME_CH)
   );

   always #5 CLK_100 = ~CLK_100;
   always @(posedge CLK_100) cyc_cnt <= cyc_cnt + 1;

`ifdef DAC_LDAC_EN
   int ldac_lows = 0;
   always @(negedge CLK_100) if (!LDAC_N) ldac_lows <= ldac_lows + 1;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      RESET_N  = 1'b0;
      CH_VALID = '0;
      repeat (2) @(negedge CLK_100);
      RESET_N = 1'b1;
      @(negedge CLK_100);
   endtask

   // Waits for a LOAD, then records the shifted word and timing up to FRAME_DONE.
   // Cycle index c counts edges after the LOAD cycle (LOAD itself is c=0).
   task automatic run_frame(input logic [N-1:0] clear_after, input logic [N-1:0] drop_in_load,
                            output logic [N-1:0] rdy, output logic [23:0] word, output int done_cyc,
                            output logic [3:0] fch, output int nrise, output int bad_hi,
                            output int extra_rdy, output int load_cyc);
      logic seen, prev_sclk;
      int   hi_run;
      rdy = '0; word = '0; done_cyc = -1; fch = '0; nrise = 0; bad_hi = 0; extra_rdy = 0;
      load_cyc = 0; seen = 1'b0;
      for (int w = 0; w < 300 && !seen; w++) begin
         @(negedge CLK_100);
         if (|CH_READY) seen = 1'b1;
      end
      check("load_seen", 32'(seen), 32'd1);
      if (!seen) return;
      rdy      = CH_READY;
      load_cyc = cyc_cnt;
      CH_VALID = CH_VALID & ~(drop_in_load & rdy);
      prev_sclk = 1'b0;
      hi_run    = 0;
      for (int c = 1; c <= 150; c++) begin
         @(negedge CLK_100);
         if (c == 1) begin
            CH_VALID = CH_VALID & ~(clear_after & rdy);
            for (int i = 0; i < N; i++)
               if (drop_in_load[i] && rdy[i]) CH_DATA[16*i +: 16] = 16'hDEAD;
         end
         if (|CH_READY) extra_rdy++;
         if (SCLK) begin
            if (!prev_sclk) begin
               word = {word[22:0], DIN};
               nrise++;
            end
            hi_run++;
         end else begin
            if (prev_sclk && hi_run != CLK_DIV) bad_hi++;
            hi_run = 0;
         end
         prev_sclk = SCLK;
         if (FRAME_DONE) begin
            done_cyc = c;
            fch      = FRAME_CH;
            break;
         end
      end
   endtask

   logic [N-1:0] rdy;
   logic [23:0]  word;
   logic [3:0]   fch;
   int           done_cyc, nrise, bad_hi, extra_rdy, load_cyc, prev_load, cnt, first_rdy;
   logic [N-1:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [23:0]  exp_rw [5] = '{24'h300000, 24'h310001, 24'h320002, 24'h330003, 24'h300000};

   initial begin
      RESET_N  = 1'b0;
      CH_VALID = '0;
      CH_DATA  = '0;
      repeat (2) @(negedge CLK_100);
      check("rst_sync",  32'(SYNC), 32'd1);
      check("rst_sclk",  32'(SCLK), 32'd0);
      check("rst_din",   32'(DIN), 32'd0);
      check("rst_ready", 32'(CH_READY), 32'd0);
      check("rst_busy",  32'(BUSY), 32'd0);
      check("rst_done",  32'(FRAME_DONE), 32'd0);
      check("rst_fch",   32'(FRAME_CH), 32'd0);
      RESET_N = 1'b1;
      @(negedge CLK_100);

      // Single channel 0, 16'hA55A -> 24'h30A55A.
      CH_DATA[15:0] = 16'hA55A;
      CH_VALID      = 4'b0001;
      run_frame(4'hF, 4'h0, rdy, word, done_cyc, fch, nrise, bad_hi, extra_rdy, load_cyc);
      check("single_ready", 32'(rdy), 32'h1);
      check("single_ready_once", 32'(extra_rdy), 32'd0);
      check("single_word", 32'(word), 32'h30A55A);
      check("single_rises", 32'(nrise), 32'd24);
      check("single_hi_len", 32'(bad_hi), 32'd0);
      // 97 edges after LOAD, i.e. cycle 98 counting LOAD as cycle 1.
      check("single_done_cyc", 32'(done_cyc), 32'd97);
      check("single_fch", 32'(fch), 32'd0);
      check("gap1_sync", 32'(SYNC), 32'd1);
      check("gap1_din", 32'(DIN), 32'd0);
      @(negedge CLK_100);
      check("gap2_sync", 32'(SYNC), 32'd1);
      check("gap2_busy", 32'(BUSY), 32'd1);
      check("gap2_done_pulse", 32'(FRAME_DONE), 32'd0);
      @(negedge CLK_100);
      check("idle_busy", 32'(BUSY), 32'd0);

      // Round-robin with all four continuously valid.
      do_reset();
      for (int i = 0; i < N; i++) CH_DATA[16*i +: 16] = 16'(i);
      CH_VALID  = 4'b1111;
      prev_load = 0;
      for (int f = 0; f < 5; f++) begin
         run_frame(4'h0, 4'h0, rdy, word, done_cyc, fch, nrise, bad_hi, extra_rdy, load_cyc);
         check($sformatf("rr_ready%0d", f), 32'(rdy), 32'(exp_rr[f]));
         check($sformatf("rr_word%0d", f), 32'(word), 32'(exp_rw[f]));
         check($sformatf("rr_fch%0d", f), 32'(fch), 32'(exp_rw[f][19:16]));
         if (f > 0) check($sformatf("rr_period%0d", f), 32'(load_cyc - prev_load), 32'd100);
         prev_load = load_cyc;
      end

      // Skip and wrap: pointer left at 3 by a ch2 frame, then ch0/ch2 requests.
      do_reset();
      CH_DATA[15:0]  = 16'h1111;
      CH_DATA[47:32] = 16'h2222;
      CH_VALID = 4'b0100;
      run_frame(4'hF, 4'h0, rdy, word, done_cyc, fch, nrise, bad_hi, extra_rdy, load_cyc);
      check("skip_pre_word", 32'(word), 32'h322222);
      CH_VALID = 4'b0101;
      run_frame(4'hF, 4'h0, rdy, word, done_cyc, fch, nrise, bad_hi, extra_rdy, load_cyc);
      check("skip_first_ready", 32'(rdy), 32'h1);
      check("skip_first_word", 32'(word), 32'h301111);
      run_frame(4'hF, 4'h0, rdy, word, done_cyc, fch, nrise, bad_hi, extra_rdy, load_cyc);
      check("skip_second_ready", 32'(rdy), 32'h4);
      check("skip_second_word", 32'(word), 32'h322222);

      // VALID dropped during LOAD: frame carries the LOAD-time data.
      do_reset();
      CH_DATA[31:16] = 16'hBEEF;
      CH_VALID       = 4'b0010;
      run_frame(4'h0, 4'hF, rdy, word, done_cyc, fch, nrise, bad_hi, extra_rdy, load_cyc);
      check("drop_load_ready", 32'(rdy), 32'h2);
      check("drop_load_word", 32'(word), 32'h31BEEF);
      check("drop_load_fch", 32'(fch), 32'd1);
      // VALID raised only during GAP and dropped before IDLE: never granted.
      CH_DATA[15:0] = 16'h0042;
      CH_VALID      = 4'b0001;
      run_frame(4'hF, 4'h0, rdy, word, done_cyc, fch, nrise, bad_hi, extra_rdy, load_cyc);
      check("drop_pre_word0", 32'(word), 32'h300042);
      CH_VALID = 4'b0010;
      @(negedge CLK_100);
      CH_VALID = 4'b0000;
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK_100);
         if (|CH_READY) cnt++;
      end
      check("drop_pre_no_grant", 32'(cnt), 32'd0);

      // Reset during bit 10 of a ch1 frame.
      do_reset();
      CH_DATA[31:16] = 16'h5678;
      CH_VALID       = 4'b0010;
      cnt = 0;
      for (int c = 0; c < 300 && cnt < 14; c++) begin
         @(negedge CLK_100);
         if (SCLK && !DIN) cnt = cnt;
         if (SCLK && dut.SCLK && c > 0) ;
         if (SCLK && (cnt == 0 || !prev_sclk_q())) cnt++;
      end
      check("midrst_reached", 32'(cnt), 32'd14);
      RESET_N = 1'b0;
      CH_VALID = '0;
      #1;
      check("midrst_sync", 32'(SYNC), 32'd1);
      check("midrst_sclk", 32'(SCLK), 32'd0);
      check("midrst_din", 32'(DIN), 32'd0);
      @(negedge CLK_100);
      RESET_N = 1'b1;
      @(negedge CLK_100);
      CH_DATA[47:32] = 16'h1234;
      CH_VALID       = 4'b0100;
      run_frame(4'hF, 4'h0, rdy, word, done_cyc, fch, nrise, bad_hi, extra_rdy, load_cyc);
      check("midrst_ready", 32'(rdy), 32'h4);
      check("midrst_word", 32'(word), 32'h321234);

`ifdef DAC_LDAC_EN
      do_reset();
      cnt = ldac_lows;
      for (int i = 0; i < N; i++) CH_DATA[16*i +: 16] = 16'(16'hA0 + i);
      CH_VALID = 4'b1111;
      for (int f = 0; f < 4; f++) begin
         run_frame(4'hF, 4'h0, rdy, word, done_cyc, fch, nrise, bad_hi, extra_rdy, load_cyc);
         check($sformatf("ldac_word%0d", f), 32'(word), 32'({4'h0, 4'(f), 16'(16'hA0 + f)}));
      end
      check("ldac_no_early", 32'(ldac_lows - cnt), 32'd0);
      check("ldac_high_gap", 32'(LDAC_N), 32'd1);
      CH_VALID  = 4'b0001;
      cnt       = 0;
      first_rdy = -1;
      bad_hi    = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge CLK_100);
         if (!LDAC_N) begin
            cnt++;
            if (|CH_READY) bad_hi++;
         end
         if (first_rdy < 0 && |CH_READY) first_rdy = c;
      end
      check("ldac_low_len", 32'(cnt), 32'd4);
      check("ldac_no_load", 32'(bad_hi), 32'd0);
      check("ldac_next_load", 32'(first_rdy), 32'd7);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // SCLK value one cycle earlier, used to count rising edges in the mid-frame reset test.
   logic sclk_d1 = 1'b0;
   always @(negedge CLK_100) sclk_d1 <= SCLK;
   function automatic logic prev_sclk_q();
      return sclk_d1;
   endfunction

endmodule
